weight_bank: RTL and testbench

- Parametrised multi-neuron weight store for one fully-connected layer: NUM_NEURONS independent block-RAM banks, each DEPTH words of DATA_WIDTH bits.
- Host side: valid/ready write port loads weights one word at a time.
- Compute side: after `start`, a sequencer streams all banks in parallel, address 0..DEPTH-1, as one wide word per beat.
- The stream uses a valid/ready handshake with backpressure, so the MAC array consumes one input index per accepted beat.

---
 rtl/weight_bank_pkg.sv | 15 +
 rtl/weight_bank_ram.sv | 30 +++
 rtl/weight_bank.sv | 146 ++++++++++++++
 tb/tb_weight_bank.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_bank_pkg.sv
// Shared types and helpers for the multi-bank weight store.
package weight_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // $clog2 with a floor of 1 so single-entry dimensions still get a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// One neuron's weight bank: single-port RAM with registered, held read data.
module weight_bank_ram #(
  parameter int DEPTH      = 784,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  (* ramstyle = "M9K" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write wins the single port; the read register only loads on re_i so a
  // stalled beat stays stable at the output.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_bank.sv
// Weight store for one fully-connected layer: host loads words one at a time,
// then a pass streams every bank in parallel, one input index per accepted beat.
//
//   state     | meaning
//   ST_IDLE   | host writes accepted, waiting for start
//   ST_STREAM | issuing reads 0..DEPTH-1, one per advance
//   ST_DRAIN  | last read issued, waiting for the out_last beat to be taken
module weight_bank
  import weight_bank_pkg::*;
#(
  parameter int NUM_NEURONS  = 16,
  parameter int DEPTH        = 784,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = clog2_min1(DEPTH),
  parameter int NEURON_WIDTH = clog2_min1(NUM_NEURONS)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [NEURON_WIDTH-1:0]           wr_neuron_i,
  input  logic [ADDR_WIDTH-1:0]             wr_addr_i,
  input  logic [DATA_WIDTH-1:0]             wr_data_i,
  output logic                              wr_err_o,
  input  logic                              start_i,
  output logic                              busy_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_weights_o,
  output logic [ADDR_WIDTH-1:0]             out_index_o,
  output logic                              out_last_o,
  output logic                              done_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rc_q, rc_d;
  logic                  done_q, done_d;
  logic                  wr_err_q;
  logic                  out_valid_q, out_last_q;
  logic [ADDR_WIDTH-1:0] out_index_q;

  logic                  wr_fire, wr_in_range;
  logic                  adv, rd_en, rc_last;
  logic [ADDR_WIDTH-1:0] ram_addr;

  assign wr_ready_o  = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign wr_fire     = wr_valid_i & wr_ready_o;
  assign wr_in_range = (32'(wr_neuron_i) < 32'(NUM_NEURONS)) &&
                       (32'(wr_addr_i) < 32'(DEPTH));

  // The output stage may load whenever it is empty or being drained this cycle.
  assign adv      = ~out_valid_q | out_ready_i;
  assign rd_en    = (state_q == ST_STREAM) & adv;
  assign rc_last  = (rc_q == ADDR_WIDTH'(DEPTH - 1));
  // Writes only happen in IDLE and reads only outside it, so one port suffices.
  assign ram_addr = (state_q == ST_IDLE) ? wr_addr_i : rc_q;

  // Next-state, read counter and done pulse.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_STREAM;
          rc_d    = '0;
        end
      end
      ST_STREAM: begin
        if (adv) begin
          if (rc_last) begin
            state_d = ST_DRAIN;
          end else begin
            rc_d = rc_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready_i && out_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, counter and status pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rc_q     <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      done_q   <= done_d;
      wr_err_q <= wr_fire & ~wr_in_range;
    end
  end

  // Beat sideband registered alongside the bank read registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= rd_en;
      if (rd_en) begin
        out_index_q <= rc_q;
        out_last_q  <= rc_last;
      end else begin
        out_last_q  <= 1'b0;
      end
    end
  end

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_bank
    logic bank_we;
    assign bank_we = wr_fire & wr_in_range & (wr_neuron_i == NEURON_WIDTH'(n));

    weight_bank_ram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk_i   (clk_i),
      .we_i    (bank_we),
      .re_i    (rd_en),
      .addr_i  (ram_addr),
      .wdata_i (wr_data_i),
      .rdata_o (out_weights_o[n*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign wr_err_o    = wr_err_q;
  assign out_valid_o = out_valid_q;
  assign out_index_o = out_index_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_weight_bank.sv
// Self-checking bench for weight_bank against an array model of the banks.
module tb_weight_bank;
  localparam int NN    = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AW    = 3;
  // One extra select bit so out-of-range banks (e.g. 5) can be addressed.
  localparam int NW    = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              wr_valid_i = 1'b0;
  logic              wr_ready_o;
  logic [NW-1:0]     wr_neuron_i = '0;
  logic [AW-1:0]     wr_addr_i = '0;
  logic [DW-1:0]     wr_data_i = '0;
  logic              wr_err_o;
  logic              start_i = 1'b0;
  logic              busy_o;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [NN*DW-1:0]  out_weights_o;
  logic [AW-1:0]     out_index_o;
  logic              out_last_o;
  logic              done_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [NN][DEPTH];

  weight_bank #(
    .NUM_NEURONS(NN), .DEPTH(DEPTH), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .NEURON_WIDTH(NW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_neuron_i(wr_neuron_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_err_o(wr_err_o), .start_i(start_i), .busy_o(busy_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_weights_o(out_weights_o), .out_index_o(out_index_o),
    .out_last_o(out_last_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [NN*DW-1:0] exp_word(input int k);
    logic [NN*DW-1:0] w;
    w = '0;
    for (int n = 0; n < NN; n++) w[n*DW +: DW] = model[n][k];
    return w;
  endfunction

  task automatic write_word(input int n, input int a, input logic [DW-1:0] d);
    int  guard;
    bit  exp_err;
    guard = 0;
    exp_err = (n >= NN) || (a >= DEPTH);
    wr_valid_i = 1'b1; wr_neuron_i = NW'(n); wr_addr_i = AW'(a); wr_data_i = d;
    while (wr_ready_o !== 1'b1 && guard < 100) begin
      @(posedge clk_i); #1; guard++;
    end
    checks++;
    if (wr_ready_o !== 1'b1) begin
      errors++; $display("FAIL write_ready got %b want 1", wr_ready_o);
    end
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0;
    if (!exp_err) model[n][a] = d;
    checks++;
    if (wr_err_o !== exp_err) begin
      errors++; $display("FAIL wr_err n=%0d a=%0d got %b want %b", n, a, wr_err_o, exp_err);
    end
  endtask

  task automatic do_stream(input int stall_at, input int stall_len, input bit rand_bp,
                           input bit poke_start, input bit poke_wr, output int done_cyc);
    int cyc, beats, dones, stall_rem;
    bit prev_stalled, accept, poked, wr_started, wr_pending, wr_fire;
    logic [AW-1:0]    prev_idx;
    logic [NN*DW-1:0] prev_w;
    stall_rem = stall_len; done_cyc = -1; beats = 0; dones = 0;
    prev_stalled = 0; poked = 0; wr_started = 0; wr_pending = 0;
    prev_idx = '0; prev_w = '0;
    start_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL start_state busy=%b valid=%b want busy=1 valid=0", busy_o, out_valid_o);
    end
    @(posedge clk_i); #1;
    cyc = 1;
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++; $display("FAIL first_valid_latency got %b want 1", out_valid_o);
    end
    while (cyc < 300 && !(done_cyc >= 0 && cyc >= done_cyc + 3 && !wr_pending)) begin
      start_i = 1'b0;
      wr_fire = 0;
      if (done_o === 1'b1) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        checks++;
        if (beats != DEPTH) begin
          errors++; $display("FAIL done_beats got %0d want %0d", beats, DEPTH);
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc) begin
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
          errors++; $display("FAIL post_done_idle busy=%b valid=%b want 0 0", busy_o, out_valid_o);
        end
      end
      if (busy_o === 1'b1) begin
        checks++;
        if (wr_ready_o !== 1'b0) begin
          errors++; $display("FAIL wr_ready_busy got %b want 0", wr_ready_o);
        end
      end
      if (out_valid_o === 1'b1) begin
        checks++;
        if (beats >= DEPTH) begin
          errors++; $display("FAIL extra_beat index=%0d beats=%0d", out_index_o, beats);
        end else if (out_index_o !== AW'(beats) || out_weights_o !== exp_word(beats) ||
                     out_last_o !== (beats == DEPTH - 1)) begin
          errors++;
          $display("FAIL beat got idx=%0d w=%h last=%b want idx=%0d w=%h last=%b",
                   out_index_o, out_weights_o, out_last_o, beats, exp_word(beats), beats == DEPTH - 1);
        end
      end
      if (prev_stalled) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_index_o !== prev_idx || out_weights_o !== prev_w) begin
          errors++;
          $display("FAIL stall_hold got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                   out_valid_o, out_index_o, out_weights_o, prev_idx, prev_w);
        end
      end
      if (out_valid_o === 1'b1 && int'(out_index_o) == stall_at && stall_rem > 0) begin
        out_ready_i = 1'b0; stall_rem--;
      end else if (rand_bp) begin
        out_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready_i = 1'b1;
      end
      if (poke_start && !poked && out_valid_o === 1'b1 && int'(out_index_o) == 4) begin
        start_i = 1'b1; poked = 1;
      end
      if (poke_wr && !wr_started && out_valid_o === 1'b1 && int'(out_index_o) == 2) begin
        wr_valid_i = 1'b1; wr_neuron_i = NW'(1); wr_addr_i = AW'(0); wr_data_i = 8'h55;
        wr_started = 1; wr_pending = 1;
      end
      if (wr_pending && wr_ready_o === 1'b1) begin
        checks++;
        if (done_o !== 1'b1) begin
          errors++; $display("FAIL wr_land_cycle done=%b want 1 on first ready", done_o);
        end
        wr_fire = 1;
      end
      prev_stalled = (out_valid_o === 1'b1) && !out_ready_i;
      prev_idx = out_index_o;
      prev_w = out_weights_o;
      accept = (out_valid_o === 1'b1) && out_ready_i;
      @(posedge clk_i); #1;
      cyc++;
      if (accept) beats++;
      if (wr_fire) begin
        wr_valid_i = 1'b0; wr_pending = 0; model[1][0] = 8'h55;
      end
    end
    start_i = 1'b0; out_ready_i = 1'b1; wr_valid_i = 1'b0;
    checks++;
    if (dones != 1 || beats != DEPTH) begin
      errors++; $display("FAIL stream_count dones=%0d beats=%0d want 1 %0d", dones, beats, DEPTH);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if (wr_ready_o !== 1'b1 || wr_err_o !== 1'b0 || busy_o !== 1'b0 || out_valid_o !== 1'b0 ||
        out_last_o !== 1'b0 || done_o !== 1'b0 || out_index_o !== '0) begin
      errors++;
      $display("FAIL reset_state rdy=%b err=%b busy=%b v=%b last=%b done=%b idx=%0d",
               wr_ready_o, wr_err_o, busy_o, out_valid_o, out_last_o, done_o, out_index_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_load_stream();
    int dc;
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) write_word(n, a, DW'(16 * n + a));
    do_stream(-1, 0, 0, 0, 0, dc);
    checks++;
    if (dc != 9) begin
      errors++; $display("FAIL stream_throughput done_cycle got %0d want 9", dc);
    end
  endtask

  task automatic test_backpressure();
    int dc;
    do_stream(3, 3, 0, 0, 0, dc);
    checks++;
    if (dc != 12) begin
      errors++; $display("FAIL backpressure done_cycle got %0d want 12", dc);
    end
  endtask

  task automatic test_out_of_range();
    int dc;
    write_word(5, 2, 8'hAA);
    @(posedge clk_i); #1;
    checks++;
    if (wr_err_o !== 1'b0) begin
      errors++; $display("FAIL wr_err_single_pulse got %b want 0", wr_err_o);
    end
    do_stream(-1, 0, 0, 0, 0, dc);
  endtask

  task automatic test_write_busy();
    int dc;
    do_stream(-1, 0, 0, 0, 1, dc);
    checks++;
    if (model[1][0] !== 8'h55) begin
      errors++; $display("FAIL write_busy_not_landed model=%h want 55", model[1][0]);
    end
    do_stream(-1, 0, 0, 0, 0, dc);
  endtask

  task automatic test_start_busy();
    int dc;
    do_stream(-1, 0, 0, 1, 0, dc);
  endtask

  task automatic test_reset_mid();
    int guard, dc;
    guard = 0;
    start_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    while (!(out_valid_o === 1'b1 && int'(out_index_o) == 5) && guard < 50) begin
      @(posedge clk_i); #1; guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++; $display("FAIL reset_mid_reach_beat5 idx=%0d want 5", out_index_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_immediate v=%b busy=%b done=%b want 0 0 0",
                         out_valid_o, busy_o, done_o);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
        errors++; $display("FAIL reset_mid_quiet done=%b busy=%b v=%b want 0 0 0",
                           done_o, busy_o, out_valid_o);
      end
    end
    do_stream(-1, 0, 0, 0, 0, dc);
  endtask

  task automatic test_random();
    int dc;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++)
        write_word(int'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      do_stream(-1, 0, 1, 0, 0, dc);
    end
  endtask

  initial begin
    test_reset();
    test_load_stream();
    test_backpressure();
    test_out_of_range();
    test_write_busy();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
